// File: rtl/acc_bank_pkg.sv
// Shared definitions for the accumulator bank: operation encoding, flag bit
// positions and the channel-select width helper.
package acc_bank_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    // A single-channel bank still needs a one-bit select.
    function automatic int cw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/acc_bank_if.sv
// Operation/read bus of the accumulator bank; master issues operations,
// slave is the bank itself.
interface acc_bank_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 2
);
    logic             acc_enable;
    logic [1:0]       op;
    logic [CW-1:0]    ch_sel;
    logic [WIDTH-1:0] data_in;
    logic [CW-1:0]    rd_sel;
    logic [WIDTH-1:0] data_out;
    logic [3:0]       flags;
    logic             done;
    logic             err;

    modport master (
        output acc_enable, op, ch_sel, data_in, rd_sel,
        input  data_out, flags, done, err
    );

    modport slave (
        input  acc_enable, op, ch_sel, data_in, rd_sel,
        output data_out, flags, done, err
    );
endinterface

// File: rtl/acc_bank_alu.sv
// Combinational result/flag computation for one accumulator operation.
// Optional macro ACC_BANK_SAT_EN clamps signed overflow of ADD/SUB.
module acc_bank_alu
    import acc_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] raw_s;
    logic             carry_s;
    logic             ovf_s;

    // Raw arithmetic; the extra sum bit is carry-out for ADD and borrow for SUB.
    always_comb begin
        sum_s   = '0;
        raw_s   = '0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (op)
            OP_LOAD: raw_s = operand;
            OP_ADD: begin
                sum_s   = {1'b0, cur} + {1'b0, operand};
                raw_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = (cur[MSB] == operand[MSB]) && (raw_s[MSB] != cur[MSB]);
            end
            OP_SUB: begin
                sum_s   = {1'b0, cur} - {1'b0, operand};
                raw_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = (cur[MSB] != operand[MSB]) && (raw_s[MSB] != cur[MSB]);
            end
            OP_CLEAR: raw_s = '0;
            default:  raw_s = '0;
        endcase
    end

`ifdef ACC_BANK_SAT_EN
    // Overflow direction follows the sign of the current value.
    always_comb begin
        if (ovf_s) begin
            result = cur[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            result = raw_s;
        end
    end
`else
    // Wrapping build: the raw modular result is written as-is.
    always_comb begin
        result = raw_s;
    end
`endif

    // Flags describe the value actually written.
    always_comb begin
        flags             = 4'b0000;
        flags[FLAG_ZERO]  = (result == '0);
        flags[FLAG_NEG]   = result[MSB];
        flags[FLAG_CARRY] = carry_s;
        flags[FLAG_OVF]   = ovf_s;
    end

endmodule

// File: rtl/acc_bank.sv
// Bank of CHANNELS accumulators with registered flags, done pulse and sticky
// error. Build with ACC_BANK_SAT_EN for saturating ADD/SUB.
module acc_bank
    import acc_bank_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input logic       clk,
    input logic       reset,
    acc_bank_if.slave bus
);
    localparam int            CW     = cw_of(CHANNELS);
    localparam logic [CW:0]   CH_LIM = (CW + 1)'(CHANNELS);

    logic [WIDTH-1:0] acc_r [CHANNELS];
    logic [3:0]       flags_r;
    logic             done_r;
    logic             err_r;

    logic             ch_ok_s;
    logic [WIDTH-1:0] cur_s;
    logic [WIDTH-1:0] rd_data_s;
    logic [WIDTH-1:0] alu_result_s;
    logic [3:0]       alu_flags_s;

    assign ch_ok_s = ({1'b0, bus.ch_sel} < CH_LIM);

    // Select operand and read data; out-of-range selects match nothing and give zero.
    always_comb begin
        cur_s     = '0;
        rd_data_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cur_s     = cur_s     | ((bus.ch_sel == CW'(i)) ? acc_r[i] : '0);
            rd_data_s = rd_data_s | ((bus.rd_sel == CW'(i)) ? acc_r[i] : '0);
        end
    end

    acc_bank_alu #(.WIDTH(WIDTH)) u_alu (
        .op      (op_e'(bus.op)),
        .cur     (cur_s),
        .operand (bus.data_in),
        .result  (alu_result_s),
        .flags   (alu_flags_s)
    );

    // Accumulator array, flags, done pulse and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i] <= '0;
            end
            flags_r <= 4'b0000;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.acc_enable) begin
                if (ch_ok_s) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (bus.ch_sel == CW'(i)) begin
                            acc_r[i] <= alu_result_s;
                        end
                    end
                    flags_r <= alu_flags_s;
                    done_r  <= 1'b1;
                end else begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out = rd_data_s;
    assign bus.flags    = flags_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_acc_bank.sv
// Self-checking bench for acc_bank: a 4-channel bank against an arithmetic
// reference model, plus a 3-channel bank for out-of-range selects.
module tb_acc_bank;
    import acc_bank_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] m_acc [4];
    logic [3:0]  m_flags;

    acc_bank_if #(.WIDTH(16), .CW(2)) bus4 ();
    acc_bank_if #(.WIDTH(16), .CW(2)) bus3 ();

    acc_bank #(.WIDTH(16), .CHANNELS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    acc_bank #(.WIDTH(16), .CHANNELS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, flags as {ovf, carry, neg, zero}.
    task automatic model_op(input logic [1:0] op, input int ch, input logic [15:0] d);
        int ua, ud, ur, sa, sd, sr;
        logic c, v;
        logic [15:0] res;
        ua = int'(m_acc[ch]);
        ud = int'(d);
        sa = int'($signed(m_acc[ch]));
        sd = int'($signed(d));
        c = 1'b0; v = 1'b0; res = 16'h0000;
        case (op)
            2'b00: res = d;
            2'b01: begin
                ur = ua + ud; sr = sa + sd;
                c = (ur > 65535); v = (sr > 32767) || (sr < -32768);
                res = ur[15:0];
`ifdef ACC_BANK_SAT_EN
                if (v) res = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
            end
            2'b10: begin
                ur = ua - ud; sr = sa - sd;
                c = (ua < ud); v = (sr > 32767) || (sr < -32768);
                res = ur[15:0];
`ifdef ACC_BANK_SAT_EN
                if (v) res = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
            end
            default: res = 16'h0000;
        endcase
        m_acc[ch] = res;
        m_flags = {v, c, res[15], (res == 16'h0000)};
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_acc[i] = 16'h0000;
        m_flags = 4'b0000;
    endtask

    // One clock of stimulus on the 4-channel bank; returns #1 after the edge.
    task automatic step(input logic en, input logic [1:0] op, input logic [1:0] ch, input logic [15:0] d);
        @(negedge clk);
        bus4.acc_enable = en; bus4.op = op; bus4.ch_sel = ch;
        bus4.data_in = d; bus4.rd_sel = ch;
        @(posedge clk); #1;
        bus4.acc_enable = 1'b0;
        if (en) model_op(op, int'(ch), d);
    endtask

    task automatic step3(input logic en, input logic [1:0] op, input logic [1:0] ch, input logic [15:0] d);
        @(negedge clk);
        bus3.acc_enable = en; bus3.op = op; bus3.ch_sel = ch;
        bus3.data_in = d; bus3.rd_sel = ch;
        @(posedge clk); #1;
        bus3.acc_enable = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            bus4.rd_sel = 2'(i); #1;
            checks++;
            if (bus4.data_out !== 16'h0000) begin
                errors++; $display("FAIL reset_acc%0d got %h want 0000", i, bus4.data_out);
            end
        end
        checks++;
        if ({bus4.flags, bus4.done, bus4.err, bus3.err} !== 7'b0) begin
            errors++; $display("FAIL reset_ctl got flags=%b done=%b err=%b/%b want all 0",
                               bus4.flags, bus4.done, bus4.err, bus3.err);
        end
    endtask

    task automatic test_load();
        step(1'b1, OP_LOAD, 2'd0, 16'hAAAA);
        checks++;
        if (bus4.data_out !== 16'hAAAA || bus4.flags !== 4'b0010 || bus4.done !== 1'b1) begin
            errors++; $display("FAIL load got data=%h flags=%b done=%b want aaaa 0010 1",
                               bus4.data_out, bus4.flags, bus4.done);
        end
        step(1'b0, OP_ADD, 2'd0, 16'h1111);
        checks++;
        if (bus4.data_out !== 16'hAAAA || bus4.flags !== 4'b0010 || bus4.done !== 1'b0) begin
            errors++; $display("FAIL idle_hold got data=%h flags=%b done=%b want aaaa 0010 0",
                               bus4.data_out, bus4.flags, bus4.done);
        end
    endtask

    task automatic test_add_ovf();
        logic [15:0] exp_d;
        logic [3:0]  exp_f;
`ifdef ACC_BANK_SAT_EN
        exp_d = 16'h7FFF; exp_f = 4'b1000;
`else
        exp_d = 16'h8000; exp_f = 4'b1010;
`endif
        step(1'b1, OP_LOAD, 2'd1, 16'h7FFF);
        step(1'b1, OP_ADD, 2'd1, 16'h0001);
        checks++;
        if (bus4.data_out !== exp_d || bus4.flags !== exp_f) begin
            errors++; $display("FAIL add_ovf got %h/%b want %h/%b", bus4.data_out, bus4.flags, exp_d, exp_f);
        end
    endtask

    task automatic test_sub_borrow();
        step(1'b1, OP_LOAD, 2'd2, 16'h0000);
        checks++;
        if (bus4.flags !== 4'b0001) begin
            errors++; $display("FAIL load_zero got flags=%b want 0001", bus4.flags);
        end
        step(1'b1, OP_SUB, 2'd2, 16'h0001);
        checks++;
        if (bus4.data_out !== 16'hFFFF || bus4.flags !== 4'b0110) begin
            errors++; $display("FAIL sub_borrow got %h/%b want ffff/0110", bus4.data_out, bus4.flags);
        end
        step(1'b1, OP_ADD, 2'd2, 16'h0001);
        checks++;
        if (bus4.data_out !== 16'h0000 || bus4.flags !== 4'b0101) begin
            errors++; $display("FAIL add_wrap got %h/%b want 0000/0101", bus4.data_out, bus4.flags);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 4; i++) step(1'b1, OP_LOAD, 2'(i), 16'(16'h1357 * (i + 1)));
        step(1'b1, OP_CLEAR, 2'd3, 16'hBEEF);
        checks++;
        if (bus4.data_out !== 16'h0000 || bus4.flags !== 4'b0001 || bus4.done !== 1'b1) begin
            errors++; $display("FAIL clear got %h/%b done=%b want 0000/0001 1",
                               bus4.data_out, bus4.flags, bus4.done);
        end
        for (int i = 0; i < 4; i++) begin
            bus4.rd_sel = 2'(i); #1;
            checks++;
            if (bus4.data_out !== m_acc[i]) begin
                errors++; $display("FAIL clear_keep%0d got %h want %h", i, bus4.data_out, m_acc[i]);
            end
        end
    endtask

    // Random ops, with frequent boundary operands and back-to-back same-channel runs.
    task automatic test_back_to_back_random();
        logic        en;
        logic [1:0]  op, ch;
        logic [15:0] d;
        logic [15:0] edges [4];
        edges[0] = 16'h0000; edges[1] = 16'h7FFF; edges[2] = 16'h8000; edges[3] = 16'hFFFF;
        for (int n = 0; n < 300; n++) begin
            en = ($urandom_range(0, 4) != 0);
            op = 2'($urandom_range(0, 3));
            ch = (n % 8 < 4) ? 2'd1 : 2'($urandom_range(0, 3));
            d  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
            step(en, op, ch, d);
            checks++;
            if (bus4.data_out !== m_acc[ch] || bus4.flags !== m_flags || bus4.done !== en) begin
                errors++; $display("FAIL rand%0d op=%0d ch=%0d d=%h got %h/%b/%b want %h/%b/%b",
                                   n, op, ch, d, bus4.data_out, bus4.flags, bus4.done,
                                   m_acc[ch], m_flags, en);
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus4.rd_sel = 2'(i); #1;
            checks++;
            if (bus4.data_out !== m_acc[i]) begin
                errors++; $display("FAIL rand_final%0d got %h want %h", i, bus4.data_out, m_acc[i]);
            end
        end
    endtask

    task automatic test_bad_channel();
        step3(1'b1, OP_LOAD, 2'd0, 16'hC3C3);
        step3(1'b1, OP_ADD, 2'd3, 16'h0001);
        checks++;
        if (bus3.err !== 1'b1 || bus3.done !== 1'b0 || bus3.flags !== 4'b0010 || bus3.data_out !== 16'h0000) begin
            errors++; $display("FAIL bad_ch got err=%b done=%b flags=%b rd3=%h want 1 0 0010 0000",
                               bus3.err, bus3.done, bus3.flags, bus3.data_out);
        end
        bus3.rd_sel = 2'd0; #1;
        checks++;
        if (bus3.data_out !== 16'hC3C3) begin
            errors++; $display("FAIL bad_ch_keep got %h want c3c3", bus3.data_out);
        end
        step3(1'b0, OP_ADD, 2'd0, 16'h0001);
        step3(1'b1, OP_ADD, 2'd0, 16'h0001);
        checks++;
        if (bus3.err !== 1'b1 || bus3.data_out !== 16'hC3C4 || bus3.done !== 1'b1) begin
            errors++; $display("FAIL err_sticky got err=%b data=%h done=%b want 1 c3c4 1",
                               bus3.err, bus3.data_out, bus3.done);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, OP_LOAD, 2'd0, 16'h4321);
        @(negedge clk);
        bus4.acc_enable = 1'b1; bus4.op = OP_LOAD; bus4.ch_sel = 2'd3;
        bus4.data_in = 16'h5555; bus4.rd_sel = 2'd0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus4.data_out, bus4.flags, bus4.done, bus3.err, bus3.data_out} !== 38'b0) begin
            errors++; $display("FAIL async_reset got data=%h flags=%b done=%b err3=%b",
                               bus4.data_out, bus4.flags, bus4.done, bus3.err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        bus4.acc_enable = 1'b0;
        reset = 1'b0;
        model_reset();
        bus4.rd_sel = 2'd3; #1;
        checks++;
        if (bus4.data_out !== 16'h0000 || bus4.done !== 1'b0) begin
            errors++; $display("FAIL reset_discard got %h done=%b want 0000 0", bus4.data_out, bus4.done);
        end
        step(1'b1, OP_ADD, 2'd2, 16'h1234);
        checks++;
        if (bus4.data_out !== 16'h1234 || bus4.flags !== 4'b0000 || bus4.done !== 1'b1) begin
            errors++; $display("FAIL first_after_reset got %h/%b done=%b want 1234/0000 1",
                               bus4.data_out, bus4.flags, bus4.done);
        end
    endtask

    initial begin
        bus4.acc_enable = 1'b0; bus4.op = 2'b00; bus4.ch_sel = 2'd0;
        bus4.data_in = 16'h0000; bus4.rd_sel = 2'd0;
        bus3.acc_enable = 1'b0; bus3.op = 2'b00; bus3.ch_sel = 2'd0;
        bus3.data_in = 16'h0000; bus3.rd_sel = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_load();
        test_add_ovf();
        test_sub_borrow();
        test_clear();
        test_back_to_back_random();
        test_bad_channel();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
